// File: rtl/parking_passcode_entry_if.sv
// Keypad / result bundle between the passcode entry block and its user.
//   master: drives start, key_valid, key_digit, key_clear; observes results.
//   slave : the passcode entry block itself.
// Ports: start, key_valid, key_digit[3:0], key_clear (to slave);
//        pass_ok, pass_fail, timeout, locked, busy, digit_count, tries_left (from slave).
interface parking_passcode_entry_if #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 3
) ();
    logic                               start;
    logic                               key_valid;
    logic [3:0]                         key_digit;
    logic                               key_clear;
    logic                               pass_ok;
    logic                               pass_fail;
    logic                               timeout;
    logic                               locked;
    logic                               busy;
    logic [$clog2(DIGITS+1)-1:0]        digit_count;
    logic [$clog2(MAX_TRIES+1)-1:0]     tries_left;

    modport master (
        output start, key_valid, key_digit, key_clear,
        input  pass_ok, pass_fail, timeout, locked, busy, digit_count, tries_left
    );

    modport slave (
        input  start, key_valid, key_digit, key_clear,
        output pass_ok, pass_fail, timeout, locked, busy, digit_count, tries_left
    );
endinterface

// File: rtl/parking_passcode_entry.sv
// Keypad passcode collector/checker for the parking gate.
// Opens a session on start, shifts in decimal digits, checks the completed
// code against PASSCODE and pulses pass_ok / pass_fail for one cycle.
// Wrong codes use up tries; running out of tries enters a timed lockout.
// Inactivity in ENTRY abandons the session with a timeout pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of parking_passcode_entry_if (keys in, results out)
//
// state   | meaning
// IDLE    | no session; waiting for start
// ENTRY   | collecting digits, inactivity timer running
// CHECK   | one cycle comparing the full code
// LOCKOUT | too many wrong codes; ignore everything for LOCK_CYCLES
module parking_passcode_entry #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] PASSCODE       = 16'h1234,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCK_CYCLES    = 1000,
    parameter int                  TIMEOUT_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      reset,
    parking_passcode_entry_if.slave   bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          pass_ok_q, pass_ok_d;
    logic          pass_fail_q, pass_fail_d;
    logic          timeout_q, timeout_d;

    logic          accept;
    logic [BW-1:0] shifted;

    assign accept = bus.key_valid && (bus.key_digit <= 4'd9);

    // With a single digit there is nothing older to keep in the buffer.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign shifted = bus.key_digit;
        end else begin : g_shift_many
            assign shifted = {buf_q[BW-5:0], bus.key_digit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            tries_q     <= TW'(MAX_TRIES);
            idle_q      <= '0;
            lock_q      <= '0;
            pass_ok_q   <= 1'b0;
            pass_fail_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            tries_q     <= tries_d;
            idle_q      <= idle_d;
            lock_q      <= lock_d;
            pass_ok_q   <= pass_ok_d;
            pass_fail_q <= pass_fail_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        tries_d     = tries_q;
        idle_d      = idle_q;
        lock_d      = lock_q;
        pass_ok_d   = 1'b0;
        pass_fail_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tries_d = TW'(MAX_TRIES);
                    idle_d  = '0;
                end
            end

            ENTRY: begin
                if (bus.key_clear) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    idle_d = '0;
                end else if (accept) begin
                    buf_d  = shifted;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        state_d = CHECK;
                        idle_d  = '0;
                    end else begin
                        idle_d  = '0;
                    end
                end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                    // Invalid keys land here too: they never refresh the timer.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    idle_d    = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end

            CHECK: begin
                if (buf_q == PASSCODE) begin
                    pass_ok_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    pass_fail_d = 1'b1;
                    if (tries_q > TW'(1)) begin
                        tries_d = tries_q - TW'(1);
                        buf_d   = '0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        state_d = ENTRY;
                    end else begin
                        tries_d = '0;
                        lock_d  = '0;
                        state_d = LOCKOUT;
                    end
                end
            end

            LOCKOUT: begin
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    lock_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.pass_ok     = pass_ok_q;
    assign bus.pass_fail   = pass_fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.locked      = (state_q == LOCKOUT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.digit_count = cnt_q;
    assign bus.tries_left  = tries_q;
endmodule

// File: tb/tb_parking_passcode_entry.sv
// Bench for parking_passcode_entry: directed scenarios followed by random
// keypad traffic, every cycle compared against a queue-based session model.
module tb_parking_passcode_entry;
    localparam int DIGITS    = 4;
    localparam int MAX_TRIES = 3;
    localparam int LOCK      = 1000;
    localparam int TO        = 500;
    localparam int PASS      = 'h1234;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_passcode_entry_if #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) bus ();

    parking_passcode_entry #(
        .DIGITS(DIGITS), .PASSCODE(16'h1234), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Session model: digits held in a queue, lockout as remaining cycles,
    // inactivity as number of consecutive idle cycles.
    bit m_session  = 0;
    bit m_checking = 0;
    int m_lock_left = 0;
    int m_tries     = MAX_TRIES;
    int m_quiet     = 0;
    int m_q[$];
    bit m_ok = 0, m_fail = 0, m_to = 0;

    function automatic int pass_digit(input int i);
        return (PASS >> (4 * (DIGITS - 1 - i))) & 15;
    endfunction

    function automatic bit code_matches();
        for (int i = 0; i < DIGITS; i++)
            if (m_q[i] != pass_digit(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model(input bit r, input bit st, input bit kv, input int kd, input bit kc);
        m_ok = 0; m_fail = 0; m_to = 0;
        if (r) begin
            m_session = 0; m_checking = 0; m_lock_left = 0;
            m_tries = MAX_TRIES; m_quiet = 0; m_q.delete();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_checking) begin
            m_checking = 0;
            if (code_matches()) begin
                m_ok = 1; m_session = 0;
            end else begin
                m_fail = 1;
                m_tries--;
                if (m_tries == 0) begin
                    m_session = 0; m_lock_left = LOCK;
                end else begin
                    m_q.delete(); m_quiet = 0;
                end
            end
        end else if (m_session) begin
            if (kc) begin
                m_q.delete(); m_quiet = 0;
            end else if (kv && kd <= 9) begin
                m_q.push_back(kd); m_quiet = 0;
                if (m_q.size() == DIGITS) m_checking = 1;
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_to = 1; m_session = 0;
                end
            end
        end else if (st) begin
            m_session = 1; m_q.delete(); m_tries = MAX_TRIES; m_quiet = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pass_ok",     32'(bus.pass_ok),     32'(m_ok));
        chk("pass_fail",   32'(bus.pass_fail),   32'(m_fail));
        chk("timeout",     32'(bus.timeout),     32'(m_to));
        chk("locked",      32'(bus.locked),      32'(m_lock_left > 0));
        chk("busy",        32'(bus.busy),        32'(m_session || m_checking || m_lock_left > 0));
        chk("digit_count", 32'(bus.digit_count), 32'(m_q.size()));
        chk("tries_left",  32'(bus.tries_left),  32'(m_tries));
    endtask

    task automatic step(input bit r, input bit st, input bit kv, input int kd, input bit kc);
        reset         = r;
        bus.start     = st;
        bus.key_valid = kv;
        bus.key_digit = kd[3:0];
        bus.key_clear = kc;
        @(posedge clk);
        model(r, st, kv, kd, kc);
        #1;
        check_all();
    endtask

    task automatic idle();          step(0, 0, 0, 0, 0); endtask
    task automatic key(input int d); step(0, 0, 1, d, 0); endtask
    task automatic go();            step(0, 1, 0, 0, 0); endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        int n;
        int kd;
        bit r, st, kv, kc;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_tries", 32'(bus.tries_left), 32'(MAX_TRIES));

        // Correct code on first attempt
        go();
        enter(1, 2, 3, 4);
        idle();
        chk("ok_pulse", 32'(bus.pass_ok), 32'd1);
        chk("ok_idle",  32'(bus.busy),    32'd0);
        idle();

        // One wrong code, then the right one
        go();
        enter(9, 9, 9, 9);
        idle();
        chk("retry_fail",  32'(bus.pass_fail),  32'd1);
        chk("retry_tries", 32'(bus.tries_left), 32'd2);
        enter(1, 2, 3, 4);
        idle();
        chk("retry_ok", 32'(bus.pass_ok), 32'd1);

        // Three wrong codes and the lockout window
        go();
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter(9, 9, 9, 9);
            idle();
        end
        n = 0;
        while (bus.locked === 1'b1 && n < LOCK + 100) begin
            n++;
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), 0);
        end
        chk("lock_len", 32'(n), 32'(LOCK));
        idle();

        // Clear beats a simultaneous key; invalid keys are dropped
        go();
        key(1); key(2);
        step(0, 0, 1, 7, 1);
        chk("clear_cnt", 32'(bus.digit_count), 32'd0);
        key('hA);
        enter(1, 2, 3, 4);
        idle();
        chk("clear_ok", 32'(bus.pass_ok), 32'd1);

        // Inactivity timeout, plain and with an invalid key in the middle
        go();
        key(1);
        for (int i = 0; i < TO; i++) idle();
        chk("timeout_pulse", 32'(bus.timeout), 32'd1);
        go();
        key(1);
        for (int i = 0; i < 299; i++) idle();
        key('hF);
        for (int i = 0; i < TO - 300; i++) idle();
        chk("timeout_bad_key", 32'(bus.timeout), 32'd1);
        idle();

        // Reset in the middle of entry
        go();
        key(1); key(2); key(3);
        step(1, 0, 0, 0, 0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        key(4);
        idle();
        chk("rst_no_pulse", 32'(bus.pass_ok | bus.pass_fail), 32'd0);

        // Random keypad traffic, biased toward the real passcode
        for (int i = 0; i < 6000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            st = ($urandom_range(0, 9) == 0);
            kc = ($urandom_range(0, 29) == 0);
            kv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0 && m_q.size() < DIGITS)
                kd = pass_digit(m_q.size());
            else
                kd = $urandom_range(0, 15);
            step(r, st, kv, kd, kc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
